// File: rtl/serial_add_scheduler_if.sv
// Bundle of the requester, serial-adder and response signals of serial_add_scheduler.
// master: the scheduler side; slave: the clients, the adder and the response consumer.
interface serial_add_scheduler_if #(
   parameter int unsigned N_REQ = 2,
   parameter int unsigned W     = 8,
   parameter int unsigned IDW   = $clog2(N_REQ)
);
   logic [N_REQ-1:0]   req_vld;
   logic [N_REQ-1:0]   req_rdy;
   logic [N_REQ*W-1:0] req_a;
   logic [N_REQ*W-1:0] req_b;
   logic               add_vld;
   logic               add_a;
   logic               add_b;
   logic               add_last;
   logic               add_sum;
   logic               rsp_vld;
   logic               rsp_rdy;
   logic [IDW-1:0]     rsp_id;
   logic [W-1:0]       rsp_sum;

   modport master (
      input  req_vld, req_a, req_b, add_sum, rsp_rdy,
      output req_rdy, add_vld, add_a, add_b, add_last, rsp_vld, rsp_id, rsp_sum
   );

   modport slave (
      output req_vld, req_a, req_b, add_sum, rsp_rdy,
      input  req_rdy, add_vld, add_a, add_b, add_last, rsp_vld, rsp_id, rsp_sum
   );
endinterface

// File: rtl/serial_add_scheduler.sv
// Round-robin scheduler sharing one bit-serial LSB-first adder between N_REQ requesters.
// Operands are shifted out one bit per cycle; returned sum bits are collected and the
// W-bit result is presented with the owner ID on a valid/ready response port.
module serial_add_scheduler #(
   parameter int unsigned N_REQ = 2,
   parameter int unsigned W     = 8,
   parameter int unsigned IDW   = $clog2(N_REQ)
) (
   input  logic                   clk,
   input  logic                   rst,
   serial_add_scheduler_if.master bus
);
   localparam int unsigned CW = $clog2(W);

   typedef enum logic [1:0] {StIdle, StShift, StResp} state_e;

   state_e         state_q, state_d;
   logic [CW-1:0]  cnt_q;
   logic [W-1:0]   a_q, b_q, sum_q;
   logic [IDW-1:0] id_q, last_grant_q;

   logic           grant_vld;
   logic [IDW-1:0] winner;
   logic [W-1:0]   win_a, win_b;
   logic           cnt_last;

   assign cnt_last = (cnt_q == CW'(W - 1));

   // Round-robin search starting just above the previous winner, wrapping to 0.
   always_comb begin
      int idx;
      grant_vld = 1'b0;
      winner    = '0;
      win_a     = '0;
      win_b     = '0;
      for (int off = 1; off <= int'(N_REQ); off++) begin
         idx = (int'(last_grant_q) + off) % int'(N_REQ);
         if (!grant_vld && bus.req_vld[idx]) begin
            grant_vld = 1'b1;
            winner    = IDW'(idx);
            win_a     = bus.req_a[idx*W +: W];
            win_b     = bus.req_b[idx*W +: W];
         end
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state and all port outputs; idle values first.
   always_comb begin
      state_d      = state_q;
      bus.req_rdy  = '0;
      bus.add_vld  = 1'b0;
      bus.add_a    = 1'b0;
      bus.add_b    = 1'b0;
      bus.add_last = 1'b0;
      bus.rsp_vld  = 1'b0;
      bus.rsp_id   = id_q;
      bus.rsp_sum  = sum_q;
      unique case (state_q)
         StIdle: begin
            if (grant_vld) begin
               bus.req_rdy[winner] = 1'b1;
               state_d             = StShift;
            end
         end
         StShift: begin
            bus.add_vld  = 1'b1;
            bus.add_a    = a_q[cnt_q];
            bus.add_b    = b_q[cnt_q];
            bus.add_last = cnt_last;
            if (cnt_last) state_d = StResp;
         end
         StResp: begin
            bus.rsp_vld = 1'b1;
            if (bus.rsp_rdy) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // Operand capture on accept, bit counter and sum collection while shifting.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q        <= '0;
         a_q          <= '0;
         b_q          <= '0;
         sum_q        <= '0;
         id_q         <= '0;
         last_grant_q <= IDW'(N_REQ - 1);
      end else begin
         if (state_q == StIdle && grant_vld) begin
            a_q          <= win_a;
            b_q          <= win_b;
            id_q         <= winner;
            last_grant_q <= winner;
            cnt_q        <= '0;
         end
         if (state_q == StShift) begin
            sum_q[cnt_q] <= bus.add_sum;
            cnt_q        <= cnt_last ? '0 : cnt_q + CW'(1);
         end
      end
   end
endmodule
